// File: rtl/l1_bus_responder.sv
// =====================================================================
// l1_bus_responder: turns L1 miss/RFO/writeback/upgrade requests into L2
// bus messages and MESI grants. Optional event counters: L2_STATS_EN. Rev 1.0
// =====================================================================
`default_nettype none

module l1_bus_responder #(
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 4,
  parameter int MSG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              snoop_shared,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_mesi,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [1:0]        msg_code,
  output logic [ADDR_W-1:0] msg_addr,
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_rfos,
  output logic [15:0]       stat_wbs
);

  localparam int c_ptr_w = $clog2(MSG_DEPTH);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(MSG_DEPTH);
  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  localparam logic [1:0] c_op_read    = 2'd0;
  localparam logic [1:0] c_op_rfo     = 2'd1;
  localparam logic [1:0] c_op_wb      = 2'd2;
  localparam logic [1:0] c_op_upgrade = 2'd3;

  localparam logic [1:0] c_bus_read  = 2'd0;
  localparam logic [1:0] c_bus_write = 2'd1;
  localparam logic [1:0] c_bus_rfo   = 2'd2;
  localparam logic [1:0] c_bus_inv   = 2'd3;

  localparam logic [1:0] c_mesi_i = 2'b00;
  localparam logic [1:0] c_mesi_s = 2'b01;
  localparam logic [1:0] c_mesi_e = 2'b10;
  localparam logic [1:0] c_mesi_m = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_shared;
  logic [3:0]          r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [1:0]          r_rsp_mesi;

  logic [1:0]          r_code_mem [MSG_DEPTH];
  logic [ADDR_W-1:0]   r_addr_mem [MSG_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w:0]    r_count;

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_msg_code;
  logic [1:0]          w_grant;

  assign w_accept = req_valid && r_req_ready;
  // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
  assign w_push   = (r_state == ST_MSG) && (r_count < c_depth);
  assign w_pop    = (r_count != '0) && msg_ready;

  always_comb begin
    w_msg_code = c_bus_read;
    case (r_op)
      c_op_read:    w_msg_code = c_bus_read;
      c_op_rfo:     w_msg_code = c_bus_rfo;
      c_op_wb:      w_msg_code = c_bus_write;
      c_op_upgrade: w_msg_code = c_bus_inv;
      default:      w_msg_code = c_bus_read;
    endcase
  end

  always_comb begin
    w_grant = c_mesi_i;
    case (r_op)
      c_op_read:    w_grant = r_shared ? c_mesi_s : c_mesi_e;
      c_op_rfo:     w_grant = c_mesi_m;
      c_op_upgrade: w_grant = c_mesi_m;
      default:      w_grant = c_mesi_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 2'd0;
      r_addr      <= '0;
      r_shared    <= 1'b0;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_mesi  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_op        <= req_op;
            r_addr      <= req_addr;
            r_shared    <= snoop_shared;
            r_req_ready <= 1'b0;
            r_state     <= ST_MSG;
          end
        end
        ST_MSG: begin
          if (w_push) begin
            if (r_op == c_op_upgrade) begin
              // Upgrades need no data from L2, so they skip the latency model.
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_addr  <= r_addr;
              r_rsp_mesi  <= w_grant;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= c_lat_m1;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= r_addr;
            r_rsp_mesi  <= w_grant;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_code_mem[r_wr_ptr] <= w_msg_code;
      r_addr_mem[r_wr_ptr] <= r_addr;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_mesi  = r_rsp_mesi;
  assign msg_valid = (r_count != '0);
  // Head is masked when empty so storage needs no reset and outputs read 0.
  assign msg_code  = msg_valid ? r_code_mem[r_rd_ptr] : 2'b00;
  assign msg_addr  = msg_valid ? r_addr_mem[r_rd_ptr] : '0;

`ifdef L2_STATS_EN
  logic [15:0] r_stat_reads;
  logic [15:0] r_stat_rfos;
  logic [15:0] r_stat_wbs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_reads <= 16'd0;
      r_stat_rfos  <= 16'd0;
      r_stat_wbs   <= 16'd0;
    end else if (w_accept) begin
      if (req_op == c_op_read && r_stat_reads != 16'hFFFF) r_stat_reads <= r_stat_reads + 16'd1;
      if (req_op == c_op_rfo  && r_stat_rfos  != 16'hFFFF) r_stat_rfos  <= r_stat_rfos + 16'd1;
      if (req_op == c_op_wb   && r_stat_wbs   != 16'hFFFF) r_stat_wbs   <= r_stat_wbs + 16'd1;
    end
  end

  assign stat_reads = r_stat_reads;
  assign stat_rfos  = r_stat_rfos;
  assign stat_wbs   = r_stat_wbs;
`else
  assign stat_reads = 16'd0;
  assign stat_rfos  = 16'd0;
  assign stat_wbs   = 16'd0;
`endif

endmodule

`default_nettype wire
